// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug-page selector.
// Holds the page enum, the default debounce length and the data width.
package dbg_pkg;

  typedef enum logic [1:0] {
    PAGE_PC     = 2'd0,
    PAGE_INSTR  = 2'd1,
    PAGE_RF     = 2'd2,
    PAGE_RETIRE = 2'd3
  } dbg_page_e;

  localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;
  localparam int unsigned XLEN = 32;

endpackage

// File: rtl/dbg_display_sel_if.sv
// Board/CPU/display bundle around the debug-page selector.
// master = stimulus side (buttons, CPU state); slave = selector side.
interface dbg_display_sel_if;
  import dbg_pkg::*;

  logic            btn_next;
  logic            btn_half;
  logic            sw_freeze;
  logic [XLEN-1:0] cpu_pc;
  logic [XLEN-1:0] cpu_instr;
  logic [XLEN-1:0] cpu_rf_data;
  logic            cpu_retire;
  logic [XLEN-1:0] dbg_data;
  logic [1:0]      page;
  logic            half;
  logic            frozen;

  modport master (
    output btn_next, btn_half, sw_freeze,
    output cpu_pc, cpu_instr, cpu_rf_data,
    output cpu_retire,
    input  dbg_data, page, half, frozen
  );

  modport slave (
    input  btn_next, btn_half, sw_freeze,
    input  cpu_pc, cpu_instr, cpu_rf_data,
    input  cpu_retire,
    output dbg_data, page, half, frozen
  );

endinterface

// File: rtl/btn_debounce.sv
// 2-FF synchronizer + counter debounce for one raw board input.
// Ports: clk, reset_n, raw in; stable level and one-cycle rise pulse out.
module btn_debounce
  import dbg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int unsigned CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          stable_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync     <= '0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      sync     <= {sync[0], raw};
      stable_q <= stable;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = stable & ~stable_q;

endmodule

// File: rtl/dbg_display_sel.sv
// Debug-page selector feeding the 7-seg driver; DBG_RETIRE_CNT_EN
// enables the retire counter (page 3). Ports: buttons, CPU state, display.
module dbg_display_sel
  import dbg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            btn_next,
  input  logic            btn_half,
  input  logic            sw_freeze,
  input  logic [XLEN-1:0] cpu_pc,
  input  logic [XLEN-1:0] cpu_instr,
  input  logic [XLEN-1:0] cpu_rf_data,
  input  logic            cpu_retire,
  output logic [XLEN-1:0] dbg_data,
  output logic [1:0]      page,
  output logic            half,
  output logic            frozen
);

  logic next_stable, next_rise;
  logic half_stable, half_rise;
  logic frz_rise;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_next),
    .stable  (next_stable),
    .rise    (next_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_half (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_half),
    .stable  (half_stable),
    .rise    (half_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_frz (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (sw_freeze),
    .stable  (frozen),
    .rise    (frz_rise)
  );

  dbg_page_e page_q;
  logic      half_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      page_q <= PAGE_PC;
      half_q <= 1'b0;
    end else begin
      if (next_rise)
        page_q <= dbg_page_e'(page_q + 2'd1);
      if (half_rise)
        half_q <= ~half_q;
    end
  end

  assign page = page_q;
  assign half = half_q;

  logic [XLEN-1:0] retire_src;

`ifdef DBG_RETIRE_CNT_EN
  logic [XLEN-1:0] retire_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      retire_cnt <= '0;
    else if (cpu_retire)
      retire_cnt <= retire_cnt + XLEN'(1);
  end

  assign retire_src = retire_cnt;

  logic unused;
  assign unused = ^{next_stable, half_stable, frz_rise};
`else
  assign retire_src = '0;

  logic unused;
  assign unused = ^{next_stable, half_stable, frz_rise, cpu_retire};
`endif

  // All four pages load together so a frozen view is one coherent cycle.
  logic [XLEN-1:0] snap [4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++)
        snap[i] <= '0;
    end else if (!frozen) begin
      snap[PAGE_PC]     <= cpu_pc;
      snap[PAGE_INSTR]  <= cpu_instr;
      snap[PAGE_RF]     <= cpu_rf_data;
      snap[PAGE_RETIRE] <= retire_src;
    end
  end

  logic [XLEN-1:0] sel;
  assign sel = snap[page_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      dbg_data <= '0;
    else
      dbg_data <= {16'h0, half_q ? sel[31:16] : sel[15:0]};
  end

endmodule

// File: tb/tb_dbg_display_sel.sv
// Directed bench for dbg_display_sel with DEBOUNCE_CYCLES = 4.
// Vector table for paging, hand sequences for timing corners.
module tb_dbg_display_sel;

  localparam int unsigned DB = 4;
  localparam int unsigned LAT = 2 + DB + 1;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  dbg_display_sel_if bus ();

  dbg_display_sel #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_next    (bus.btn_next),
    .btn_half    (bus.btn_half),
    .sw_freeze   (bus.sw_freeze),
    .cpu_pc      (bus.cpu_pc),
    .cpu_instr   (bus.cpu_instr),
    .cpu_rf_data (bus.cpu_rf_data),
    .cpu_retire  (bus.cpu_retire),
    .dbg_data    (bus.dbg_data),
    .page        (bus.page),
    .half        (bus.half),
    .frozen      (bus.frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        nxt;
    logic        hlf;
    logic [1:0]  pg;
    logic        hf;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [14];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Clean press and release, each held past the debounce window.
  task automatic press(input logic n, input logic h);
    bus.btn_next = n;
    bus.btn_half = h;
    tick(LAT + 1);
    bus.btn_next = 1'b0;
    bus.btn_half = 1'b0;
    tick(LAT + 1);
  endtask

  task automatic chk_view(input string nm, input logic [1:0] pg,
                          input logic hf, input logic [31:0] d);
    chk({nm, ".page"}, 32'(bus.page), 32'(pg));
    chk({nm, ".half"}, 32'(bus.half), 32'(hf));
    chk({nm, ".data"}, bus.dbg_data, d);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b0, 1'b1, 2'd1, 1'b1, 32'h0000_DEAD};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 1'b1, 32'h0000_CAFE};
    vecs[2]  = '{1'b1, 1'b0, 2'd3, 1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_1234};
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_5678};
    vecs[5]  = '{1'b1, 1'b1, 2'd1, 1'b1, 32'h0000_DEAD};
    vecs[6]  = '{1'b1, 1'b0, 2'd2, 1'b1, 32'h0000_CAFE};
    vecs[7]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_F00D};
    vecs[8]  = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0000};
    vecs[9]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_5678};
    vecs[10] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_BEEF};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_F00D};
    vecs[12] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0000};
    vecs[13] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_5678};

    // Reset with random inputs
    reset_n          = 1'b0;
    bus.btn_next     = 1'($urandom);
    bus.btn_half     = 1'($urandom);
    bus.sw_freeze    = 1'($urandom);
    bus.cpu_pc       = $urandom;
    bus.cpu_instr    = $urandom;
    bus.cpu_rf_data  = $urandom;
    bus.cpu_retire   = 1'($urandom);
    tick(3);
    chk_view("rst", 2'd0, 1'b0, 32'h0);
    chk("rst.frozen", 32'(bus.frozen), 32'h0);

    bus.btn_next   = 1'b0;
    bus.btn_half   = 1'b0;
    bus.sw_freeze  = 1'b0;
    bus.cpu_retire = 1'b0;
    bus.cpu_pc     = 32'h0000_1234;
    reset_n        = 1'b1;
    tick(1);
    chk("rst.lat1", bus.dbg_data, 32'h0);
    tick(1);
    chk("rst.lat2", bus.dbg_data, 32'h0000_1234);

    bus.cpu_pc      = 32'h1234_5678;
    bus.cpu_instr   = 32'hDEAD_BEEF;
    bus.cpu_rf_data = 32'hCAFE_F00D;
    tick(3);

    // Press-to-page latency is 2 + DB + 1 edges
    bus.btn_next = 1'b1;
    tick(LAT - 1);
    chk("lat.before", 32'(bus.page), 32'd0);
    tick(1);
    chk("lat.after", 32'(bus.page), 32'd1);
    bus.btn_next = 1'b0;
    tick(LAT + 1);
    chk_view("lat", 2'd1, 1'b0, 32'h0000_BEEF);

    for (int i = 0; i < 14; i++) begin
      press(vecs[i].nxt, vecs[i].hlf);
      chk_view($sformatf("vec%0d", i), vecs[i].pg, vecs[i].hf,
               vecs[i].data);
    end

    // Bounce shorter than the window is ignored
    for (int i = 0; i < 10; i++) begin
      bus.btn_next = ~bus.btn_next;
      tick(2);
    end
    bus.btn_next = 1'b0;
    tick(10);
    chk_view("bounce", 2'd0, 1'b0, 32'h0000_5678);

    // Freeze
    bus.cpu_pc = 32'h0000_0100;
    tick(3);
    bus.sw_freeze = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.frozen) break;
    end
    chk("frz.assert", 32'(bus.frozen), 32'h1);
    bus.cpu_pc = 32'h0000_0200;
    tick(4);
    chk("frz.hold", bus.dbg_data, 32'h0000_0100);
    bus.cpu_instr = 32'h1111_2222;
    press(1'b1, 1'b0);
    chk_view("frz.pg1", 2'd1, 1'b0, 32'h0000_BEEF);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk_view("frz.pg0", 2'd0, 1'b0, 32'h0000_0100);
    bus.cpu_instr = 32'hDEAD_BEEF;
    bus.sw_freeze = 1'b0;
    tick(LAT);
    chk("unfrz.early", bus.dbg_data, 32'h0000_0100);
    tick(1);
    chk("unfrz.data", bus.dbg_data, 32'h0000_0200);
    chk("unfrz.frozen", 32'(bus.frozen), 32'h0);

    // Retire counter on page 3
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk_view("ret.pg3", 2'd3, 1'b0, 32'h0);
`ifdef DBG_RETIRE_CNT_EN
    bus.cpu_retire = 1'b1;
    tick(70000);
    bus.cpu_retire = 1'b0;
    tick(3);
    chk("ret.lo", bus.dbg_data, 32'h0000_1170);
    press(1'b0, 1'b1);
    chk_view("ret.hi", 2'd3, 1'b1, 32'h0000_0001);
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    bus.cpu_retire = 1'b1;
    tick(1);
    bus.cpu_retire = 1'b0;
    chk("ret.wrap", dut.retire_cnt, 32'h0);
    tick(3);
    chk("ret.wrap.disp", bus.dbg_data, 32'h0);
`else
    bus.cpu_retire = 1'b1;
    tick(50);
    bus.cpu_retire = 1'b0;
    tick(3);
    chk("ret.off.lo", bus.dbg_data, 32'h0);
    press(1'b0, 1'b1);
    chk_view("ret.off.hi", 2'd3, 1'b1, 32'h0);
`endif

    // Reset mid-debounce
    bus.btn_next = 1'b1;
    tick(2);
    reset_n = 1'b0;
    #1;
    chk_view("midrst", 2'd0, 1'b0, 32'h0);
    bus.btn_next = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(LAT + 3);
    chk("midrst.after", 32'(bus.page), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
